// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: op codes, flag bit
// positions within the flag vector, and the issue FSM state encoding.
package alu_pkg;

    // Operation codes carried on req_op / alu_op
    localparam int OP_DIV = 0;
    localparam int OP_MUL = 1;

    // Bit positions of the ALU-defined flags inside the L-bit flag vector
    localparam int MUL_OVF   = 0;
    localparam int DIV_REM   = 1;
    localparam int DIV_ZERO  = 2;
    localparam int DIV_OVF   = 3;
    localparam int NUM_FLAGS = 4;

    // Issue FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_flag_reg.sv
// Sticky flag register. A capture from the ALU always wins over a clear, so
// a clear that lands in the capture cycle cannot wipe the fresh result flags.
module alu_flag_reg
    import alu_pkg::*;
#(
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cap_en,
    input  logic [L-1:0] cap_flags,
    output logic [L-1:0] flags
);

    logic [L-1:0] flags_q;
    logic [L-1:0] flags_d;

    // Next flag value: capture has priority, then clear, else hold
    always_comb begin
        flags_d = flags_q;
        if (cap_en) begin
            flags_d = cap_flags;
        end else if (clr) begin
            flags_d = '0;
        end
    end

    // Flag storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/alu_issue.sv
// Single-outstanding issue stage for a fixed-latency external ALU.
// A request is latched in IDLE, the operand registers drive the ALU for
// ALU_LAT cycles, then the result is captured and held until the consumer
// takes it. req_ready/rsp_valid are registered so both stay low during reset
// and req_ready rises on the first edge after reset is released.
// ALU_LAT must be in 1..4.
module alu_issue
    import alu_pkg::*;
#(
    parameter int L       = 16,
    parameter int OP_W    = 1,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [L-1:0]    req_a,
    input  logic [L-1:0]    req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [L-1:0]    rsp_result,
    output logic [L-1:0]    rsp_flags,
    input  logic            flags_clr,
    output logic [L-1:0]    flags,
    output logic [OP_W-1:0] alu_op,
    output logic [L-1:0]    alu_a,
    output logic [L-1:0]    alu_b,
    output logic [L-1:0]    alu_flags_in,
    input  logic [L-1:0]    alu_r,
    input  logic [L-1:0]    alu_flags_out
);

    localparam int CNT_W = 3;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [L-1:0]      a_q, a_d;
    logic [L-1:0]      b_q, b_d;
    logic [L-1:0]      res_q, res_d;
    logic [L-1:0]      rspf_q, rspf_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              capture;
    logic [L-1:0]      flags_cur;

    // Next-state, operand latching, wait counter and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rspf_d  = rspf_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    cnt_d   = CNT_W'(ALU_LAT);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    res_d   = alu_r;
                    rspf_d  = alu_flags_out;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Handshake outputs follow the state being entered
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    // State, counter, operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rspf_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rspf_q  <= rspf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Sticky flags; a clear is honoured in every cycle except the capture
    alu_flag_reg #(
        .L (L)
    ) u_flag_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flags_clr),
        .cap_en    (capture),
        .cap_flags (alu_flags_out),
        .flags     (flags_cur)
    );

    assign req_ready    = ready_q;
    assign rsp_valid    = valid_q;
    assign rsp_result   = res_q;
    assign rsp_flags    = rspf_q;
    assign flags        = flags_cur;
    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_flags_in = flags_cur;

endmodule
